branch_predictor_gshare: RTL and testbench
==========================================

BRANCH_PREDICTOR_GSHARE -- requirements
Module: branch_predictor_gshare

Interface
REQ-001 Parameter XLEN, default 32, address/instruction-pointer width.
REQ-002 Parameter ENTRIES, default 1024, BHT/BTB depth (power of two, >=4); IDX = log2(ENTRIES).
REQ-003 Parameter GHR_BITS, default 8, global history length (1..IDX).
REQ-004 Parameter CTR_BITS, default 2, saturating counter width (2..4).
REQ-005 Parameter MODE, default 1, index mode: 0 = bimodal, 1 = gshare.
REQ-006 clk  in  1  single clock, all state updates on rising edge.
REQ-007 rst_n  in  1  synchronous, active-low reset.
REQ-008 pc_F  in  XLEN  fetch-stage PC.
REQ-009 pc4_F  in  XLEN  pc_F + 4.
REQ-010 idx_F  out  IDX  BHT index used for this lookup, to be piped to E with the instruction.
REQ-011 taken_F  out  1  fetch-stage taken prediction.
REQ-012 pc_next  out  XLEN  predicted next fetch PC.
REQ-013 branch_E / jump_E  in  1 each  E-stage instruction is a conditional branch / jal-jalr (mutually exclusive).
REQ-014 actual_E  in  1  branch condition outcome at E (ignored when jump_E).
REQ-015 taken_E  in  1  taken_F piped to E.
REQ-016 idx_E  in  IDX  idx_F piped to E.
REQ-017 pc_E, pc4_E, pc_target_E  in  XLEN each  E-stage PC, PC+4, resolved target.
REQ-018 pc_D  in  XLEN  PC of the instruction currently in D.
REQ-019 clear_stats  in  1  synchronous clear of statistics counters.
REQ-020 flush  out  1  misprediction, flush F/D/E younger instructions.
REQ-021 pc_restore  out  XLEN  corrected fetch PC, valid when flush=1.
REQ-022 branch_cnt, mispred_cnt  out  32 each  statistics counters.

Function
REQ-023 BTB index b = pc[IDX+1:2]; tag = pc[XLEN-1:IDX+2]; entry = {valid, is_jump, tag, target}.
REQ-024 idx_F = pc_F[IDX+1:2] when MODE=0; pc_F[IDX+1:2] XOR zero-extended GHR when MODE=1.
REQ-025 hit = BTB[b].valid and tag match; taken_F = hit and (BTB[b].is_jump or BHT[idx_F] MSB = 1), combinational.
REQ-026 pc_next = BTB[b].target when taken_F, else pc4_F.
REQ-027 resolved = jump_E or (branch_E and actual_E); correct PC = pc_target_E when resolved, else pc4_E.
REQ-028 flush = (branch_E or jump_E) and (resolved != taken_E or (resolved and pc_D != pc_target_E)), combinational, same cycle.
REQ-029 pc_restore = correct PC from REQ-027.
REQ-030 On branch_E: BHT[idx_E] increments if actual_E else decrements, saturating at 0 and 2^CTR_BITS-1.
REQ-031 On jump_E: BHT[idx_E] set to 2^CTR_BITS-1.
REQ-032 When resolved: BTB[pc_E index] written {1, jump_E, pc_E tag, pc_target_E}; not-taken branches leave BTB unchanged.
REQ-033 GHR shifts left by one with actual_E inserted at bit 0 on branch_E only; jumps do not touch GHR.
REQ-034 Same-cycle F read and E write to one entry: F observes pre-update value (no bypass).
REQ-035 branch_cnt increments on each branch_E or jump_E; mispred_cnt increments when flush=1; both saturate at 2^32-1.
REQ-036 clear_stats zeroes both counters next edge, priority over increment; tables unaffected.

Reset
REQ-037 rst_n=0 at rising edge: all BTB valid = 0, every BHT counter = 2^(CTR_BITS-1)-1 (weakly not-taken), GHR = 0, both counters = 0.
REQ-038 During and after reset: taken_F = 0, pc_next = pc4_F; flush follows REQ-028 (E inputs gated to 0 by the pipeline).
REQ-039 Reset asserted mid-update: reset wins, no table write that edge.

Verification
REQ-040 After reset, pc_F=0x100, pc4_F=0x104 -> taken_F=0, pc_next=0x104, idx_F=0x040 (MODE=0).
REQ-041 Branch at 0x200 taken to 0x180 with taken_E=0 -> flush=1, pc_restore=0x180; next lookup of 0x200 -> BTB hit, counter 2 -> taken_F=1, pc_next=0x180.
REQ-042 Same branch resolved taken 3 more times then not-taken once (taken_E=1) -> counter saturates at 3, decrements to 2, flush=1, pc_restore=0x204, mispred_cnt increments.
REQ-043 jal at 0x300 to 0x400 -> BTB is_jump set, next lookup taken_F=1 regardless of counter, GHR unchanged.
REQ-044 MODE=1, GHR=0x01, pc_F=0x008 -> idx_F=0x003; aliasing branch updates land on idx_E, not recomputed index.
REQ-045 Saturation/clear: force mispred_cnt=0xFFFFFFFF, flush -> stays 0xFFFFFFFF; clear_stats with simultaneous flush -> 0.

Source files
------------

// File: rtl/branch_predictor_gshare.sv
// rtl/branch_predictor_gshare.sv - gshare/bimodal branch predictor with BTB, flush generation and statistics
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   pc_F, pc4_F             fetch PC and fetch PC+4
//   idx_F                   BHT index used for the fetch lookup (carried to E)
//   taken_F, pc_next        fetch prediction and predicted next fetch PC
//   branch_E, jump_E        E-stage conditional branch / unconditional jump
//   actual_E                branch outcome at E
//   taken_E, idx_E          prediction and BHT index carried from F
//   pc_E, pc4_E             E-stage PC and PC+4
//   pc_target_E             resolved target at E
//   pc_D                    PC of the instruction in D
//   clear_stats             synchronous clear of the statistics counters
//   flush, pc_restore       misprediction flush and corrected fetch PC
//   branch_cnt, mispred_cnt statistics counters (saturating)

module branch_predictor_gshare #(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 1024,
    parameter int GHR_BITS = 8,
    parameter int CTR_BITS = 2,
    parameter int MODE     = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [XLEN-1:0]             pc_F,
    input  logic [XLEN-1:0]             pc4_F,
    output logic [$clog2(ENTRIES)-1:0]  idx_F,
    output logic                        taken_F,
    output logic [XLEN-1:0]             pc_next,
    input  logic                        branch_E,
    input  logic                        jump_E,
    input  logic                        actual_E,
    input  logic                        taken_E,
    input  logic [$clog2(ENTRIES)-1:0]  idx_E,
    input  logic [XLEN-1:0]             pc_E,
    input  logic [XLEN-1:0]             pc4_E,
    input  logic [XLEN-1:0]             pc_target_E,
    input  logic [XLEN-1:0]             pc_D,
    input  logic                        clear_stats,
    output logic                        flush,
    output logic [XLEN-1:0]             pc_restore,
    output logic [31:0]                 branch_cnt,
    output logic [31:0]                 mispred_cnt
);

    localparam int IDX  = $clog2(ENTRIES);
    localparam int TAGW = XLEN - IDX - 2;

    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    // Weakly not-taken: 2^(CTR_BITS-1)-1
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_MAX >> 1;

    logic                 btb_valid  [ENTRIES];
    logic                 btb_jump   [ENTRIES];
    logic [TAGW-1:0]      btb_tag    [ENTRIES];
    logic [XLEN-1:0]      btb_target [ENTRIES];
    logic [CTR_BITS-1:0]  bht        [ENTRIES];
    logic [GHR_BITS-1:0]  ghr;

    logic [IDX-1:0]       btb_idx_F;
    logic [TAGW-1:0]      tag_F;
    logic [IDX-1:0]       ghr_ext;
    logic                 hit_F;
    logic [IDX-1:0]       btb_idx_E;
    logic [TAGW-1:0]      tag_E;
    logic                 resolved;
    logic                 ctrl_E;
    logic [GHR_BITS-1:0]  ghr_shift;
    logic                 unused_pc_low;

    assign unused_pc_low = ^{pc_F[1:0], pc_E[1:0]};

    // ---------------- Fetch-side lookup ----------------
    assign btb_idx_F = pc_F[IDX+1:2];
    assign tag_F     = pc_F[XLEN-1:IDX+2];

    always_comb begin
        ghr_ext = '0;
        ghr_ext[GHR_BITS-1:0] = ghr;
    end

    assign idx_F = (MODE == 0) ? btb_idx_F : (btb_idx_F ^ ghr_ext);

    // Reads are of the registered tables only, so a same-cycle E write is
    // not visible to F until the following cycle.
    assign hit_F   = btb_valid[btb_idx_F] && (btb_tag[btb_idx_F] == tag_F);
    assign taken_F = rst_n && hit_F && (btb_jump[btb_idx_F] || bht[idx_F][CTR_BITS-1]);
    assign pc_next = taken_F ? btb_target[btb_idx_F] : pc4_F;

    // ---------------- Execute-side resolution ----------------
    assign ctrl_E     = branch_E || jump_E;
    assign resolved   = jump_E || (branch_E && actual_E);
    assign pc_restore = resolved ? pc_target_E : pc4_E;

    // A correct taken prediction still flushes if the fetched successor
    // (now in D) is not the resolved target, e.g. a stale BTB target.
    assign flush = ctrl_E &&
                   ((resolved != taken_E) || (resolved && (pc_D != pc_target_E)));

    assign btb_idx_E = pc_E[IDX+1:2];
    assign tag_E     = pc_E[XLEN-1:IDX+2];

    always_comb begin
        ghr_shift    = ghr << 1;
        ghr_shift[0] = actual_E;
    end

    // Valid bits, counters and history need a reset value
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_valid[i] <= 1'b0;
                bht[i]       <= CTR_INIT;
            end
            ghr <= '0;
        end else begin
            // The update goes to the index carried from F, never to one
            // recomputed here against the (possibly newer) history.
            if (branch_E) begin
                if (actual_E && (bht[idx_E] != CTR_MAX)) begin
                    bht[idx_E] <= bht[idx_E] + CTR_BITS'(1);
                end else if (!actual_E && (bht[idx_E] != '0)) begin
                    bht[idx_E] <= bht[idx_E] - CTR_BITS'(1);
                end
                ghr <= ghr_shift;
            end else if (jump_E) begin
                bht[idx_E] <= CTR_MAX;
            end
            if (resolved) begin
                btb_valid[btb_idx_E] <= 1'b1;
            end
        end
    end

    // Payload fields are qualified by the valid bit and need no reset
    always_ff @(posedge clk) begin
        if (rst_n && resolved) begin
            btb_jump[btb_idx_E]   <= jump_E;
            btb_tag[btb_idx_E]    <= tag_E;
            btb_target[btb_idx_E] <= pc_target_E;
        end
    end

    // ---------------- Statistics ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (clear_stats) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (ctrl_E && (branch_cnt != '1)) begin
                branch_cnt <= branch_cnt + 32'd1;
            end
            if (flush && (mispred_cnt != '1)) begin
                mispred_cnt <= mispred_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// tb/tb_branch_predictor_gshare.sv - self-checking bench for branch_predictor_gshare (bimodal and gshare instances)

module tb_branch_predictor_gshare;

    localparam int N = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_F, pc4_F, pc_E, pc4_E, pc_target_E, pc_D;
    logic        branch_E, jump_E, actual_E, clear_stats;
    logic [9:0]  idx_E0, idx_E1;
    logic        taken_E0, taken_E1;

    logic [9:0]  idx_F0, idx_F1;
    logic        taken_F0, taken_F1, flush0, flush1;
    logic [31:0] pc_next0, pc_next1, pc_restore0, pc_restore1;
    logic [31:0] branch_cnt0, branch_cnt1, mispred_cnt0, mispred_cnt1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    branch_predictor_gshare #(.MODE(0)) dut_bim (
        .clk(clk), .rst_n(rst_n), .pc_F(pc_F), .pc4_F(pc4_F), .idx_F(idx_F0),
        .taken_F(taken_F0), .pc_next(pc_next0), .branch_E(branch_E), .jump_E(jump_E),
        .actual_E(actual_E), .taken_E(taken_E0), .idx_E(idx_E0), .pc_E(pc_E),
        .pc4_E(pc4_E), .pc_target_E(pc_target_E), .pc_D(pc_D), .clear_stats(clear_stats),
        .flush(flush0), .pc_restore(pc_restore0), .branch_cnt(branch_cnt0),
        .mispred_cnt(mispred_cnt0)
    );

    branch_predictor_gshare #(.MODE(1)) dut_gs (
        .clk(clk), .rst_n(rst_n), .pc_F(pc_F), .pc4_F(pc4_F), .idx_F(idx_F1),
        .taken_F(taken_F1), .pc_next(pc_next1), .branch_E(branch_E), .jump_E(jump_E),
        .actual_E(actual_E), .taken_E(taken_E1), .idx_E(idx_E1), .pc_E(pc_E),
        .pc4_E(pc4_E), .pc_target_E(pc_target_E), .pc_D(pc_D), .clear_stats(clear_stats),
        .flush(flush1), .pc_restore(pc_restore1), .branch_cnt(branch_cnt1),
        .mispred_cnt(mispred_cnt1)
    );

    // ---------------- Reference model: [0]=bimodal, [1]=gshare ----------------
    int          m_bht [2][N];
    bit          m_v   [2][N];
    bit          m_j   [2][N];
    int unsigned m_tag [2][N];
    int unsigned m_tgt [2][N];
    int unsigned m_ghr [2];
    int unsigned m_bc  [2];
    int unsigned m_mc  [2];

    function automatic int unsigned e_idx(int m, logic [31:0] pc);
        int unsigned b = (pc >> 2) % N;
        return (m == 1) ? (b ^ m_ghr[m]) : b;
    endfunction

    function automatic bit e_taken(int m, logic [31:0] pc);
        int unsigned b = (pc >> 2) % N;
        bit hit = m_v[m][b] && (m_tag[m][b] == (pc >> 12));
        return hit && (m_j[m][b] || (m_bht[m][e_idx(m, pc)] >= 2));
    endfunction

    function automatic int unsigned e_next(int m, logic [31:0] pc);
        return e_taken(m, pc) ? m_tgt[m][(pc >> 2) % N] : pc + 4;
    endfunction

    function automatic bit in_te(int m);
        return (m == 1) ? taken_E1 : taken_E0;
    endfunction

    function automatic int unsigned in_ie(int m);
        return (m == 1) ? idx_E1 : idx_E0;
    endfunction

    function automatic bit e_res();
        return jump_E || (branch_E && actual_E);
    endfunction

    function automatic bit e_flush(int m);
        return (branch_E || jump_E) &&
               ((e_res() != in_te(m)) || (e_res() && (pc_D != pc_target_E)));
    endfunction

    function automatic int unsigned e_restore();
        return e_res() ? pc_target_E : pc4_E;
    endfunction

    task automatic m_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < N; i++) begin
                m_v[m][i]   = 1'b0;
                m_bht[m][i] = 1;
            end
            m_ghr[m] = 0;
            m_bc[m]  = 0;
            m_mc[m]  = 0;
        end
    endtask

    // Applies the effect of the coming rising edge given the present inputs
    task automatic m_edge();
        if (!rst_n) begin
            m_reset();
        end else begin
            for (int m = 0; m < 2; m++) begin
                bit fl = e_flush(m);
                int unsigned ix = in_ie(m);
                if (clear_stats) begin
                    m_bc[m] = 0;
                    m_mc[m] = 0;
                end else begin
                    if ((branch_E || jump_E) && m_bc[m] != 32'hFFFF_FFFF) m_bc[m]++;
                    if (fl && m_mc[m] != 32'hFFFF_FFFF) m_mc[m]++;
                end
                if (branch_E) begin
                    if (actual_E && m_bht[m][ix] < 3) m_bht[m][ix]++;
                    else if (!actual_E && m_bht[m][ix] > 0) m_bht[m][ix]--;
                    m_ghr[m] = ((m_ghr[m] << 1) | actual_E) % 256;
                end else if (jump_E) begin
                    m_bht[m][ix] = 3;
                end
                if (e_res()) begin
                    int unsigned b = (pc_E >> 2) % N;
                    m_v[m][b]   = 1'b1;
                    m_j[m][b]   = jump_E;
                    m_tag[m][b] = pc_E >> 12;
                    m_tgt[m][b] = pc_target_E;
                end
            end
        end
    endtask

    task automatic tick();
        m_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_e();
        branch_E = 0; jump_E = 0; actual_E = 0; clear_stats = 0;
        taken_E0 = 0; taken_E1 = 0; idx_E0 = '0; idx_E1 = '0;
        pc_E = '0; pc4_E = '0; pc_target_E = '0; pc_D = '0;
    endtask

    // E-stage stimulus with the F-stage prediction the pipeline would carry
    task automatic set_e(bit br, bit jp, bit act, logic [31:0] pc, logic [31:0] tgt, logic [31:0] pd);
        branch_E = br; jump_E = jp; actual_E = act;
        pc_E = pc; pc4_E = pc + 4; pc_target_E = tgt; pc_D = pd;
        idx_E0 = 10'(e_idx(0, pc)); idx_E1 = 10'(e_idx(1, pc));
        taken_E0 = e_taken(0, pc); taken_E1 = e_taken(1, pc);
    endtask

    task automatic set_f(logic [31:0] pc);
        pc_F = pc; pc4_F = pc + 4;
    endtask

    task automatic do_reset();
        rst_n = 0; idle_e();
        tick();
        rst_n = 1;
    endtask

    // ---------------- Tests ----------------
    task automatic test_reset();
        rst_n = 0; idle_e(); set_f(32'h100);
        m_reset();
        @(posedge clk); @(posedge clk); @(negedge clk);
        checks++; if (taken_F0 !== 1'b0) begin errors++; $display("FAIL rst_taken0 got=%b exp=0", taken_F0); end
        checks++; if (taken_F1 !== 1'b0) begin errors++; $display("FAIL rst_taken1 got=%b exp=0", taken_F1); end
        checks++; if (pc_next0 !== 32'h104) begin errors++; $display("FAIL rst_pcnext got=%h exp=104", pc_next0); end
        checks++; if (branch_cnt0 !== 32'd0 || mispred_cnt1 !== 32'd0) begin
            errors++; $display("FAIL rst_cnt got=%h/%h exp=0/0", branch_cnt0, mispred_cnt1); end
        rst_n = 1; #1;
        checks++; if (idx_F0 !== 10'h040) begin errors++; $display("FAIL idx_bim got=%h exp=040", idx_F0); end
        checks++; if (idx_F1 !== 10'h040) begin errors++; $display("FAIL idx_gs_ghr0 got=%h exp=040", idx_F1); end
        checks++; if (taken_F0 !== 1'b0 || pc_next0 !== 32'h104) begin
            errors++; $display("FAIL post_rst_pred got=%b/%h exp=0/104", taken_F0, pc_next0); end
        @(negedge clk);
    endtask

    task automatic test_branch_train();
        set_e(1, 0, 1, 32'h200, 32'h180, 32'h204); set_f(32'h200); #1;
        checks++; if (flush0 !== 1'b1 || pc_restore0 !== 32'h180) begin
            errors++; $display("FAIL first_flush got=%b/%h exp=1/180", flush0, pc_restore0); end
        checks++; if (flush1 !== e_flush(1)) begin errors++; $display("FAIL first_flush_gs got=%b exp=%b", flush1, e_flush(1)); end
        tick();
        idle_e(); set_f(32'h200); #1;
        checks++; if (taken_F0 !== 1'b1 || pc_next0 !== 32'h180) begin
            errors++; $display("FAIL btb_hit got=%b/%h exp=1/180", taken_F0, pc_next0); end
        checks++; if (taken_F1 !== e_taken(1, 32'h200) || pc_next1 !== e_next(1, 32'h200)) begin
            errors++; $display("FAIL btb_hit_gs got=%b/%h exp=%b/%h", taken_F1, pc_next1, e_taken(1, 32'h200), e_next(1, 32'h200)); end
        for (int k = 0; k < 3; k++) begin
            set_e(1, 0, 1, 32'h200, 32'h180, 32'h180); #1;
            checks++; if (flush0 !== 1'b0) begin errors++; $display("FAIL correct_taken_%0d got=%b exp=0", k, flush0); end
            tick();
        end
        set_e(1, 0, 0, 32'h200, 32'h180, 32'h180); #1;
        checks++; if (flush0 !== 1'b1 || pc_restore0 !== 32'h204) begin
            errors++; $display("FAIL nt_flush got=%b/%h exp=1/204", flush0, pc_restore0); end
        tick();
        idle_e(); set_f(32'h200); #1;
        checks++; if (mispred_cnt0 !== 32'd2 || branch_cnt0 !== 32'd5) begin
            errors++; $display("FAIL cnts got=%0d/%0d exp=2/5", mispred_cnt0, branch_cnt0); end
        checks++; if (taken_F0 !== 1'b1) begin errors++; $display("FAIL ctr2_taken got=%b exp=1", taken_F0); end
        checks++; if (mispred_cnt1 !== m_mc[1]) begin errors++; $display("FAIL cnt_gs got=%0d exp=%0d", mispred_cnt1, m_mc[1]); end
        set_e(1, 0, 0, 32'h200, 32'h180, 32'h180);
        tick();
        idle_e(); set_f(32'h200); #1;
        checks++; if (taken_F0 !== 1'b0 || pc_next0 !== 32'h204) begin
            errors++; $display("FAIL ctr1_nt got=%b/%h exp=0/204", taken_F0, pc_next0); end
    endtask

    task automatic test_jump();
        logic [9:0] ix_before;
        idle_e(); set_f(32'h300); #1;
        ix_before = idx_F1;
        set_e(0, 1, 0, 32'h300, 32'h400, 32'h304); #1;
        checks++; if (flush0 !== 1'b1 || pc_restore0 !== 32'h400) begin
            errors++; $display("FAIL jal_flush got=%b/%h exp=1/400", flush0, pc_restore0); end
        tick();
        idle_e(); set_f(32'h300); #1;
        checks++; if (taken_F0 !== 1'b1 || pc_next0 !== 32'h400) begin
            errors++; $display("FAIL jal_hit got=%b/%h exp=1/400", taken_F0, pc_next0); end
        checks++; if (idx_F1 !== ix_before) begin errors++; $display("FAIL jal_ghr got=%h exp=%h", idx_F1, ix_before); end
        for (int k = 0; k < 2; k++) begin
            set_e(1, 0, 0, 32'h300, 32'h400, 32'h304);
            tick();
        end
        idle_e(); set_f(32'h300); #1;
        checks++; if (taken_F0 !== 1'b1 || taken_F1 !== 1'b1) begin
            errors++; $display("FAIL jal_regardless got=%b/%b exp=1/1", taken_F0, taken_F1); end
    endtask

    task automatic test_gshare_index();
        logic [9:0] stale;
        do_reset();
        set_e(1, 0, 1, 32'h500, 32'h600, 32'h600);
        tick();
        idle_e(); set_f(32'h008); #1;
        checks++; if (idx_F1 !== 10'h003 || idx_F0 !== 10'h002) begin
            errors++; $display("FAIL gs_idx got=%h/%h exp=003/002", idx_F1, idx_F0); end
        stale = idx_F1;
        set_e(1, 0, 1, 32'h500, 32'h600, 32'h600);
        tick();
        set_e(1, 0, 1, 32'h008, 32'h700, 32'h700);
        idx_E1 = stale;
        tick();
        set_e(1, 0, 1, 32'h030, 32'h740, 32'h740);
        tick();
        // 0x030 now indexes entry 3 under the new history; only the stale-index update trained it
        idle_e(); set_f(32'h030); #1;
        checks++; if (taken_F1 !== 1'b1 || pc_next1 !== 32'h740) begin
            errors++; $display("FAIL alias_idx_E got=%b/%h exp=1/740", taken_F1, pc_next1); end
    endtask

    task automatic test_stats_sat_clear();
        idle_e();
        force dut_bim.mispred_cnt = 32'hFFFF_FFFF;
        #1 release dut_bim.mispred_cnt;
        m_mc[0] = 32'hFFFF_FFFF;
        set_e(1, 0, 1, 32'h900, 32'h980, 32'h904);
        taken_E0 = 0; taken_E1 = 0;
        tick();
        checks++; if (mispred_cnt0 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mis_sat got=%h exp=ffffffff", mispred_cnt0); end
        set_e(1, 0, 1, 32'h900, 32'h980, 32'h904);
        taken_E0 = 0; taken_E1 = 0; clear_stats = 1;
        #1;
        checks++; if (flush0 !== 1'b1) begin errors++; $display("FAIL clr_flush got=%b exp=1", flush0); end
        tick();
        checks++; if (mispred_cnt0 !== 32'd0 || branch_cnt0 !== 32'd0 || mispred_cnt1 !== 32'd0) begin
            errors++; $display("FAIL clear got=%h/%h/%h exp=0", mispred_cnt0, branch_cnt0, mispred_cnt1); end
        idle_e();
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            int t;
            rst_n = ($urandom_range(0, 99) != 0);
            set_f(($urandom_range(0, 1) << 12) | ($urandom_range(0, 15) << 2));
            t = $urandom_range(0, 2);
            begin
                logic [31:0] pe = ($urandom_range(0, 1) << 12) | ($urandom_range(0, 15) << 2);
                logic [31:0] tg = $urandom_range(0, 1023) << 2;
                logic [31:0] pd;
                case ($urandom_range(0, 2))
                    0: pd = tg;
                    1: pd = pe + 4;
                    default: pd = $urandom_range(0, 1023) << 2;
                endcase
                set_e(t == 1, t == 2, $urandom_range(0, 1), pe, tg, pd);
            end
            if ($urandom_range(0, 3) == 0) begin
                idx_E0 = 10'($urandom_range(0, N - 1));
                idx_E1 = 10'($urandom_range(0, N - 1));
            end
            if ($urandom_range(0, 7) == 0) begin
                taken_E0 = ~taken_E0; taken_E1 = ~taken_E1;
            end
            clear_stats = ($urandom_range(0, 49) == 0);
            #1;
            for (int m = 0; m < 2; m++) begin
                logic [9:0]  o_idx  = (m == 1) ? idx_F1 : idx_F0;
                logic        o_tk   = (m == 1) ? taken_F1 : taken_F0;
                logic [31:0] o_nx   = (m == 1) ? pc_next1 : pc_next0;
                logic        o_fl   = (m == 1) ? flush1 : flush0;
                logic [31:0] o_rs   = (m == 1) ? pc_restore1 : pc_restore0;
                logic [31:0] o_bc   = (m == 1) ? branch_cnt1 : branch_cnt0;
                logic [31:0] o_mc   = (m == 1) ? mispred_cnt1 : mispred_cnt0;
                bit          x_tk   = rst_n && e_taken(m, pc_F);
                logic [31:0] x_nx   = x_tk ? e_next(m, pc_F) : pc4_F;
                checks++; if (o_idx !== 10'(e_idx(m, pc_F))) begin
                    errors++; $display("FAIL rnd_idx c=%0d m=%0d got=%h exp=%h", c, m, o_idx, e_idx(m, pc_F)); end
                checks++; if (o_tk !== x_tk || o_nx !== x_nx) begin
                    errors++; $display("FAIL rnd_pred c=%0d m=%0d got=%b/%h exp=%b/%h", c, m, o_tk, o_nx, x_tk, x_nx); end
                checks++; if (o_fl !== e_flush(m)) begin
                    errors++; $display("FAIL rnd_flush c=%0d m=%0d got=%b exp=%b", c, m, o_fl, e_flush(m)); end
                if (e_flush(m)) begin
                    checks++; if (o_rs !== e_restore()) begin
                        errors++; $display("FAIL rnd_restore c=%0d m=%0d got=%h exp=%h", c, m, o_rs, e_restore()); end
                end
                checks++; if (o_bc !== m_bc[m] || o_mc !== m_mc[m]) begin
                    errors++; $display("FAIL rnd_cnt c=%0d m=%0d got=%0d/%0d exp=%0d/%0d", c, m, o_bc, o_mc, m_bc[m], m_mc[m]); end
            end
            tick();
        end
        rst_n = 1;
        idle_e();
    endtask

    initial begin
        test_reset();
        test_branch_train();
        test_jump();
        test_gshare_index();
        test_stats_sat_clear();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
